// File: rtl/sprite_blitter.sv
// Sprite blitter: walks one rectangular sprite out of a registered ROM and feeds
// one pixel per controller write slot. Optional horizontal mirror: BLIT_FLIP_EN.
module sprite_blitter #(
    parameter int          ROM_AW      = 14,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter logic [8:0]  DUMMY_Y     = 9'd511
) (
    input  logic              sram_clk,
    input  logic              reset,
    input  logic              slot,
    input  logic              frame_start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [5:0]        cmd_w,
    input  logic [5:0]        cmd_h,
    input  logic [ROM_AW-1:0] cmd_base,
    input  logic              cmd_flip,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [9:0]        program_x,
    output logic [8:0]        program_y,
    output logic [15:0]       program_data,
    output logic              busy,
    output logic              overrun
);

    // state | meaning
    // IDLE  | waiting for a command; slots write the dummy pixel
    // PRIME | one cycle while the ROM registers pixel (0,0)
    // DRAW  | one pixel per slot until (w,h) is consumed
    typedef enum logic [1:0] {IDLE, PRIME, DRAW} state_t;

    state_t            state_q;
    logic [9:0]        x_q;
    logic [8:0]        y_q;
    logic [5:0]        w_q;
    logic [5:0]        h_q;
    logic [5:0]        col_q;
    logic [5:0]        row_q;
    logic [ROM_AW-1:0] row_base_q;
    logic [9:0]        px_q;
    logic [8:0]        py_q;
    logic [15:0]       pd_q;
    logic              overrun_q;

    logic [10:0]       sx;
    logic [9:0]        sy;
    logic              pix_ok;
    logic              last_pix;
    logic [5:0]        col_rd;

`ifdef BLIT_FLIP_EN
    logic              flip_q;

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            flip_q <= 1'b0;
        end else if (state_q == IDLE && cmd_valid) begin
            flip_q <= cmd_flip;
        end
    end

    assign col_rd = flip_q ? (w_q - col_q) : col_q;
`else
    logic              unused_flip;

    assign unused_flip = cmd_flip;
    assign col_rd      = col_q;
`endif

    assign rom_addr = row_base_q + {{(ROM_AW-6){1'b0}}, col_rd};

    assign sx       = {1'b0, x_q} + {5'b0, col_q};
    assign sy       = {1'b0, y_q} + {4'b0, row_q};
    assign pix_ok   = (rom_data != TRANSPARENT) && (sx < 11'd640) && (sy < 10'd480);
    assign last_pix = (col_q == w_q) && (row_q == h_q);

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            px_q       <= '0;
            py_q       <= DUMMY_Y;
            pd_q       <= '0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (slot) begin
                        px_q <= '0;
                        py_q <= DUMMY_Y;
                        pd_q <= '0;
                    end
                    if (cmd_valid) begin
                        x_q        <= cmd_x;
                        y_q        <= cmd_y;
                        w_q        <= cmd_w;
                        h_q        <= cmd_h;
                        col_q      <= '0;
                        row_q      <= '0;
                        row_base_q <= cmd_base;
                        state_q    <= PRIME;
                    end
                end
                PRIME, DRAW: begin
                    if (frame_start) begin
                        // Abort wins over any coincident slot.
                        state_q   <= IDLE;
                        overrun_q <= 1'b1;
                        col_q     <= '0;
                        row_q     <= '0;
                        px_q      <= '0;
                        py_q      <= DUMMY_Y;
                        pd_q      <= '0;
                    end else if (state_q == PRIME) begin
                        if (slot) begin
                            px_q <= '0;
                            py_q <= DUMMY_Y;
                            pd_q <= '0;
                        end
                        state_q <= DRAW;
                    end else if (slot) begin
                        if (pix_ok) begin
                            px_q <= sx[9:0];
                            py_q <= sy[8:0];
                            pd_q <= rom_data;
                        end else begin
                            px_q <= '0;
                            py_q <= DUMMY_Y;
                            pd_q <= '0;
                        end
                        if (col_q < w_q) begin
                            col_q <= col_q + 6'd1;
                        end else begin
                            col_q      <= '0;
                            row_q      <= row_q + 6'd1;
                            row_base_q <= row_base_q + {{(ROM_AW-6){1'b0}}, w_q} + 1'b1;
                        end
                        if (last_pix) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign program_x    = px_q;
    assign program_y    = py_q;
    assign program_data = pd_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: table of sprite commands with hand-computed
// pixel streams, plus hand sequences for abort, reset and back-to-back corners.
module tb_sprite_blitter;

    logic        sram_clk = 1'b0;
    logic        reset = 1'b1;
    logic        slot = 1'b0;
    logic        frame_start = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0;
    logic [8:0]  cmd_y = '0;
    logic [5:0]  cmd_w = '0;
    logic [5:0]  cmd_h = '0;
    logic [13:0] cmd_base = '0;
    logic        cmd_flip = 1'b0;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [9:0]  program_x;
    logic [8:0]  program_y;
    logic [15:0] program_data;
    logic        busy;
    logic        overrun;

    logic [15:0] rom [0:16383];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
    } pix_t;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [5:0]  w;
        logic [5:0]  h;
        logic [13:0] base;
        logic        flip;
        int          n;
        int          idx;
    } cmd_t;

    pix_t ev [27];
    cmd_t ct [4];

    sprite_blitter dut (
        .sram_clk     (sram_clk),
        .reset        (reset),
        .slot         (slot),
        .frame_start  (frame_start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_w        (cmd_w),
        .cmd_h        (cmd_h),
        .cmd_base     (cmd_base),
        .cmd_flip     (cmd_flip),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .program_x    (program_x),
        .program_y    (program_y),
        .program_data (program_data),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 sram_clk = ~sram_clk;

    always @(posedge sram_clk) rom_data <= rom[rom_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sram_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_pix(input string name, input logic [9:0] x, input logic [8:0] y,
                           input logic [15:0] d);
        chk({name, "_x"}, {22'd0, program_x}, {22'd0, x});
        chk({name, "_y"}, {23'd0, program_y}, {23'd0, y});
        chk({name, "_d"}, {16'd0, program_data}, {16'd0, d});
    endtask

    task automatic slot_pulse();
        slot = 1'b1;
        tick();
        slot = 1'b0;
    endtask

    task automatic set_cmd(input logic [9:0] x, input logic [8:0] y, input logic [5:0] w,
                           input logic [5:0] h, input logic [13:0] b, input logic f);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_base = b; cmd_flip = f;
    endtask

    // Accept on the first edge, let PRIME elapse on the second.
    task automatic issue(input logic [9:0] x, input logic [8:0] y, input logic [5:0] w,
                         input logic [5:0] h, input logic [13:0] b, input logic f);
        set_cmd(x, y, w, h, b, f);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        rom[4] = 16'h1111; rom[5] = 16'hF81F; rom[6] = 16'h3333; rom[7] = 16'h4444;
        for (int i = 0; i < 16; i++) rom[16+i] = 16'h0100 + 16'(i);
        for (int i = 0; i < 4096; i++) rom[4096+i] = 16'h2000 + 16'(i);
        rom[8192] = 16'h000A; rom[8193] = 16'h000B; rom[8194] = 16'h000C;

        ev[0] = '{10'd100, 9'd50, 16'h1111};
        ev[1] = '{10'd101, 9'd50, 16'h2222};
        ev[2] = '{10'd100, 9'd51, 16'h3333};
        ev[3] = '{10'd101, 9'd51, 16'h4444};
        ev[4] = '{10'd100, 9'd50, 16'h1111};
        ev[5] = '{10'd0,   9'd511, 16'h0000};
        ev[6] = '{10'd100, 9'd51, 16'h3333};
        ev[7] = '{10'd101, 9'd51, 16'h4444};
        for (int i = 8; i < 24; i++) ev[i] = '{10'd0, 9'd511, 16'h0000};
        ev[8]  = '{10'd638, 9'd478, 16'h0100};
        ev[9]  = '{10'd639, 9'd478, 16'h0101};
        ev[12] = '{10'd638, 9'd479, 16'h0104};
        ev[13] = '{10'd639, 9'd479, 16'h0105};
`ifdef BLIT_FLIP_EN
        ev[24] = '{10'd10, 9'd20, 16'h000C};
        ev[25] = '{10'd11, 9'd20, 16'h000B};
        ev[26] = '{10'd12, 9'd20, 16'h000A};
`else
        ev[24] = '{10'd10, 9'd20, 16'h000A};
        ev[25] = '{10'd11, 9'd20, 16'h000B};
        ev[26] = '{10'd12, 9'd20, 16'h000C};
`endif

        ct[0] = '{10'd100, 9'd50,  6'd1, 6'd1, 14'd0,    1'b0, 4,  0};
        ct[1] = '{10'd100, 9'd50,  6'd1, 6'd1, 14'd4,    1'b0, 4,  4};
        ct[2] = '{10'd638, 9'd478, 6'd3, 6'd3, 14'd16,   1'b0, 16, 8};
        ct[3] = '{10'd10,  9'd20,  6'd2, 6'd0, 14'd8192, 1'b1, 3,  24};

        // Reset values
        tick(); tick();
        chk_pix("reset", 10'd0, 9'd511, 16'h0000);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        tick();

        // Idle slots write the dummy pixel
        for (int k = 0; k < 3; k++) begin
            slot_pulse();
            chk_pix("idle", 10'd0, 9'd511, 16'h0000);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
            tick();
        end

        // Table of sprite commands
        for (int t = 0; t < 4; t++) begin
            issue(ct[t].x, ct[t].y, ct[t].w, ct[t].h, ct[t].base, ct[t].flip);
            chk($sformatf("t%0d_busy", t), {31'd0, busy}, 32'd1);
            for (int k = 0; k < ct[t].n; k++) begin
                slot_pulse();
                chk_pix($sformatf("t%0d_p%0d", t, k), ev[ct[t].idx+k].x,
                        ev[ct[t].idx+k].y, ev[ct[t].idx+k].d);
                tick();
            end
            chk($sformatf("t%0d_done_busy", t), {31'd0, busy}, 32'd0);
            chk($sformatf("t%0d_done_ready", t), {31'd0, cmd_ready}, 32'd1);
            slot_pulse();
            chk_pix($sformatf("t%0d_after", t), 10'd0, 9'd511, 16'h0000);
            tick();
        end

        // Last pixel coincident with cmd_valid: finish first, accept next cycle
        issue(10'd5, 9'd6, 6'd0, 6'd0, 14'd0, 1'b0);
        slot = 1'b1;
        cmd_valid = 1'b1;
        tick();
        slot = 1'b0;
        chk_pix("chain_p0", 10'd5, 9'd6, 16'h1111);
        chk("chain_not_yet", {31'd0, busy}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("chain_accept", {31'd0, busy}, 32'd1);
        tick();
        slot_pulse();
        chk_pix("chain_p1", 10'd5, 9'd6, 16'h1111);
        chk("chain_done", {31'd0, busy}, 32'd0);
        tick();

        // frame_start in IDLE with a command: accepted, no overrun
        set_cmd(10'd5, 9'd6, 6'd0, 6'd0, 14'd0, 1'b0);
        cmd_valid = 1'b1;
        frame_start = 1'b1;
        tick();
        cmd_valid = 1'b0;
        frame_start = 1'b0;
        chk("fs_idle_busy", {31'd0, busy}, 32'd1);
        chk("fs_idle_overrun", {31'd0, overrun}, 32'd0);
        tick();
        slot_pulse();
        chk_pix("fs_idle_p0", 10'd5, 9'd6, 16'h1111);
        tick();

        // frame_start in PRIME aborts
        set_cmd(10'd5, 9'd6, 6'd0, 6'd0, 14'd0, 1'b0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_prime_overrun", {31'd0, overrun}, 32'd1);
        chk("fs_prime_busy", {31'd0, busy}, 32'd0);
        tick();

        // 64x64 sprite aborted by frame_start (coincident with a slot) after 100 slots
        issue(10'd0, 9'd0, 6'd63, 6'd63, 14'd4096, 1'b0);
        for (int k = 0; k < 100; k++) begin
            slot_pulse();
            if (k == 0)  chk_pix("big_p0",  10'd0,  9'd0, 16'h2000);
            if (k == 64) chk_pix("big_p64", 10'd0,  9'd1, 16'h2040);
            if (k == 99) chk_pix("big_p99", 10'd35, 9'd1, 16'h2063);
            tick();
        end
        chk("big_busy", {31'd0, busy}, 32'd1);
        slot = 1'b1;
        frame_start = 1'b1;
        tick();
        slot = 1'b0;
        frame_start = 1'b0;
        chk("abort_overrun", {31'd0, overrun}, 32'd1);
        chk_pix("abort_pix", 10'd0, 9'd511, 16'h0000);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        chk("abort_overrun_low", {31'd0, overrun}, 32'd0);

        issue(10'd100, 9'd50, 6'd1, 6'd1, 14'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            slot_pulse();
            chk_pix($sformatf("post_abort_p%0d", k), ev[k].x, ev[k].y, ev[k].d);
            tick();
        end
        chk("post_abort_busy", {31'd0, busy}, 32'd0);

        // Reset mid-sprite drops the command
        issue(10'd100, 9'd50, 6'd1, 6'd1, 14'd0, 1'b0);
        slot_pulse();
        chk_pix("rst_mid_p0", 10'd100, 9'd50, 16'h1111);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_pix("rst_mid", 10'd0, 9'd511, 16'h0000);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        slot_pulse();
        chk_pix("rst_mid_after", 10'd0, 9'd511, 16'h0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Upstream feeder of the SRAM frame-buffer controller. Drives its program_x/program_y/program_data write port.
- Walks one rectangular sprite at a time out of a synchronous sprite ROM and emits one pixel per controller write slot into the hidden frame.
- Transparent and off-screen pixels are redirected to an unused dummy row (y=511). Every slot still performs a harmless write.

Parameters:
- ROM_AW, 14, sprite ROM address width.
- TRANSPARENT, 16'hF81F, colour key; pixels equal to it are not drawn.
- DUMMY_Y, 9'd511, off-screen row used for idle/skipped writes (rows 480-511 are never displayed).

Ports:
- sram_clk  in  1  100 MHz clock.
- reset  in  1  synchronous, active-high.
- slot  in  1  one-cycle pulse; the controller samples program_* on the rising edge that ends this cycle; pulses are ≥2 cycles apart.
- frame_start  in  1  one-cycle pulse at a frame swap.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_x  in  10  sprite left column (screen).
- cmd_y  in  9  sprite top row.
- cmd_w  in  6  width-1 (1..64 pixels).
- cmd_h  in  6  height-1 (1..64 rows).
- cmd_base  in  ROM_AW  ROM address of sprite pixel (0,0), row-major.
- cmd_flip  in  1  horizontal mirror (see Optional Feature).
- rom_addr  out  ROM_AW  combinational from internal pointers.
- rom_data  in  16  ROM output, valid one cycle after rom_addr (registered ROM).
- program_x  out  10  registered.
- program_y  out  9  registered.
- program_data  out  16  registered.
- busy  out  1  state != IDLE.
- overrun  out  1  one-cycle pulse when a sprite is aborted by frame_start.

Behaviour:
- Reset values: program_x=0, program_y=DUMMY_Y, program_data=0, state=IDLE, cmd_ready=1, busy=0, overrun=0, all counters 0.
- States: IDLE, PRIME, DRAW.
- IDLE: when cmd_valid && cmd_ready, latch the command, set col=0, row=0, row_base=cmd_base, then go to PRIME.
- PRIME: lasts exactly 1 cycle so the ROM registers the first pixel. Then DRAW.
- Slot in IDLE or PRIME: load the dummy pixel (x=0, y=DUMMY_Y, data=0).
- Slot in DRAW: load the output registers for the current pixel (col,row):
  - sx = cmd_x + col, computed 11 bits wide.
  - sy = cmd_y + row, computed 10 bits wide.
  - If rom_data == TRANSPARENT, or sx ≥ 640, or sy ≥ 480, load the dummy pixel.
  - Otherwise load {sx[9:0], sy[8:0], rom_data}.
- Advance on the same edge as the slot:
  - If col < w: col+1.
  - Else: col=0, row+1, row_base += w+1 (no multiplier).
- rom_addr = row_base + col, truncated to ROM_AW and wrapping silently.
- After the last pixel (col==w && row==h) is consumed, go to IDLE. cmd_ready rises the next cycle.
- Program outputs hold between slots. The controller writes the held values twice per 4-cycle round, which is idempotent.
- Latency:
  - Command accept to first pixel eligible = 2 cycles; it is emitted on the first slot after that.
  - Throughput = 1 pixel per slot; a sprite costs (w+1)(h+1) slots.
- frame_start:
  - In DRAW or PRIME: abort to IDLE, pulse overrun for 1 cycle, and load the dummy pixel into the outputs on that edge.
  - In IDLE: no effect.
- frame_start coincident with slot: frame_start wins; the dummy pixel is loaded.
- frame_start coincident with a cmd accept in IDLE: the command is accepted normally.
- Reset mid-sprite: returns to reset values immediately; the command is lost.
- slot coincident with the last pixel and with cmd_valid: finish first; the new command is accepted no earlier than the next cycle in IDLE.

Optional Feature:
- Macro BLIT_FLIP_EN.
- Defined, with cmd_flip=1: the ROM column read is w-col, i.e. rom_addr = row_base + (w - col). Screen placement is unchanged (sx = cmd_x + col).
- Defined, with cmd_flip=0: normal addressing.
- Not defined: the cmd_flip port still exists but is ignored; addressing is always row_base + col.

Test Plan:
- Reset, then slots every 2 cycles with no command -> every slot sees x=0, y=511, data=0; busy=0; cmd_ready=1.
- Command x=100, y=50, w=1, h=1 (2x2), base=0, ROM[0..3]=1111,2222,3333,4444 -> the next 4 slots present (100,50,1111), (101,50,2222), (100,51,3333), (101,51,4444); then dummy; cmd_ready=1.
- Same command with ROM[1]=F81F -> slot 2 presents (0,511,0); the other three pixels are unchanged.
- Command x=638, y=478, 4x4 -> only (638..639, 478..479) are written; the other 12 slots are dummy; total 16 slots before IDLE.
- 64x64 sprite, frame_start after 100 slots -> overrun pulses 1 cycle; outputs go dummy on that edge; IDLE; the next command is accepted.
- BLIT_FLIP_EN defined, 3x1 sprite, ROM[0..2]=A,B,C, flip=1 -> slots present C, B, A at x, x+1, x+2; macro undefined -> A, B, C.
